// File: rtl/biquad_coeff_pkg.sv
// Shared constants, address-map helpers and FSM encoding for the biquad coefficient loader.
// The shadow slot of an address equals its stream-order index, so slot k is streamed k-th.
package biquad_coeff_pkg;

  localparam int unsigned COEFF_PER_STAGE = 23;
  localparam int unsigned KW              = 5;
  localparam int unsigned K_LAST          = COEFF_PER_STAGE - 1;

  localparam int unsigned FIR_A_LAST = 7;
  localparam int unsigned FIR_B_BASE = 16;
  localparam int unsigned FIR_B_LAST = 24;
  localparam int unsigned IIR_BASE   = 32;
  localparam int unsigned IIR_LAST   = 35;
  localparam int unsigned INC_BASE   = 48;
  localparam int unsigned INC_LAST   = 49;

  // First stream index of each address group
  localparam int unsigned K_FIR_A = 9;
  localparam int unsigned K_IIR   = 17;
  localparam int unsigned K_INC   = 21;

  localparam logic [KW-1:0] SLOT_INVALID = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_GAP,
    ST_UPDATE,
    ST_DONE
  } state_e;

  function automatic logic [7:0] seq_adr(input logic [KW-1:0] k);
    int unsigned ki;
    ki = 32'(k);
    if (ki < K_FIR_A) return 8'(FIR_B_LAST - ki);
    if (ki < K_IIR)   return 8'(FIR_A_LAST + K_FIR_A - ki);
    if (ki < K_INC)   return 8'(IIR_LAST + K_IIR - ki);
    return 8'(INC_LAST + K_INC - ki);
  endfunction

  function automatic logic [KW-1:0] adr_to_slot(input logic [7:0] adr);
    int unsigned a;
    a = 32'(adr);
    if (a >= FIR_B_BASE && a <= FIR_B_LAST) return KW'(FIR_B_LAST - a);
    if (a <= FIR_A_LAST)                    return KW'(K_FIR_A + FIR_A_LAST - a);
    if (a >= IIR_BASE && a <= IIR_LAST)     return KW'(K_IIR + IIR_LAST - a);
    if (a >= INC_BASE && a <= INC_LAST)     return KW'(K_INC + INC_LAST - a);
    return SLOT_INVALID;
  endfunction

endpackage

// File: rtl/biquad_coeff_shadow.sv
// Shadow coefficient store: one write port, one registered read port.
// Storage itself is never reset so values survive a reset; only the read register is.
module biquad_coeff_shadow #(
  parameter int unsigned DEPTH = 46,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/biquad_coeff_loader.sv
// Streams shadowed biquad coefficients into the selected stages in mandatory reverse order,
// holding each write for WR_HOLD clocks, then broadcasts a single coeff_update pulse.
module biquad_coeff_loader
  import biquad_coeff_pkg::*;
#(
  parameter int unsigned NUM_BIQUADS = 2,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned WR_HOLD     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_wr_i,
  input  logic [2:0]             host_stage_i,
  input  logic [7:0]             host_adr_i,
  input  logic [COEFF_WIDTH-1:0] host_dat_i,
  output logic                   host_ready_o,
  output logic                   host_err_o,
  input  logic                   commit_i,
  input  logic [NUM_BIQUADS-1:0] commit_mask_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             coeff_adr_o,
  output logic [COEFF_WIDTH-1:0] coeff_dat_o,
  output logic [NUM_BIQUADS-1:0] coeff_wr_o,
  output logic                   coeff_update_o
);

  localparam int unsigned SW    = (NUM_BIQUADS > 1) ? $clog2(NUM_BIQUADS) : 1;
  localparam int unsigned DEPTH = NUM_BIQUADS * COEFF_PER_STAGE;
  localparam int unsigned AW    = $clog2(DEPTH);

  state_e                 state_q;
  logic [NUM_BIQUADS-1:0] mask_q;
  logic [SW-1:0]          stage_q;
  logic [KW-1:0]          k_q;
  logic [7:0]             hold_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   update_q;
  logic                   err_q;
  logic [7:0]             adr_q;
  logic [NUM_BIQUADS-1:0] wr_q;

  logic [KW-1:0]          slot_c;
  logic                   wr_accept_c;
  logic                   wr_drop_c;
  logic                   commit_accept_c;
  logic [NUM_BIQUADS-1:0] rem_c;
  logic [AW-1:0]          wr_addr_c;
  logic [AW-1:0]          rd_addr_c;
  logic                   rd_en_c;

  function automatic logic [SW-1:0] first_set(input logic [NUM_BIQUADS-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    for (int i = int'(NUM_BIQUADS) - 1; i >= 0; i--) begin
      if (m[i]) r = SW'(i);
    end
    return r;
  endfunction

  // Host write qualification and shadow addressing
  always_comb begin
    slot_c          = adr_to_slot(host_adr_i);
    wr_accept_c     = host_wr_i && !busy_q && (32'(host_stage_i) < NUM_BIQUADS)
                      && (slot_c != SLOT_INVALID);
    wr_drop_c       = host_wr_i && !wr_accept_c;
    commit_accept_c = commit_i && (state_q == ST_IDLE);
    wr_addr_c       = AW'(32'(host_stage_i) * COEFF_PER_STAGE + 32'(slot_c));
    rd_addr_c       = AW'(32'(stage_q) * COEFF_PER_STAGE + 32'(k_q));
    rd_en_c         = (state_q == ST_LOAD);
    rem_c           = mask_q & ~(NUM_BIQUADS'(1) << stage_q);
  end

  biquad_coeff_shadow #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (COEFF_WIDTH)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_accept_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (host_dat_i),
    .rd_en_i   (rd_en_c),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (coeff_dat_o)
  );

  // Sticky drop flag; a fresh drop wins over a same-cycle commit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (err_q && !commit_accept_c) || wr_drop_c;
  end

  // Sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      stage_q  <= '0;
      k_q      <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      update_q <= 1'b0;
      adr_q    <= '0;
      wr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit_i) begin
            if (|commit_mask_i) begin
              mask_q  <= commit_mask_i;
              stage_q <= first_set(commit_mask_i);
              k_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          adr_q   <= seq_adr(k_q);
          wr_q    <= NUM_BIQUADS'(1) << stage_q;
          hold_q  <= '0;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (hold_q == 8'(WR_HOLD - 1)) begin
            wr_q    <= '0;
            state_q <= ST_GAP;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (32'(k_q) != K_LAST) begin
            k_q     <= k_q + KW'(1);
            state_q <= ST_LOAD;
          end else if (|rem_c) begin
            mask_q  <= rem_c;
            stage_q <= first_set(rem_c);
            k_q     <= '0;
            state_q <= ST_LOAD;
          end else begin
            update_q <= 1'b1;
            state_q  <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          update_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_ready_o   = !busy_q;
  assign host_err_o     = err_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign coeff_adr_o    = adr_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = update_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Directed bench for biquad_coeff_loader: full stream timing, ordering, host errors, abort.
module tb_biquad_coeff_loader;

  localparam int unsigned NB = 2;
  localparam int unsigned CW = 18;
  localparam int unsigned H  = 16;

  logic          clk;
  logic          rst_n;
  logic          host_wr_i;
  logic [2:0]    host_stage_i;
  logic [7:0]    host_adr_i;
  logic [CW-1:0] host_dat_i;
  logic          host_ready_o;
  logic          host_err_o;
  logic          commit_i;
  logic [NB-1:0] commit_mask_i;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    coeff_adr_o;
  logic [CW-1:0] coeff_dat_o;
  logic [NB-1:0] coeff_wr_o;
  logic          coeff_update_o;

  int errors = 0;
  int checks = 0;

  int order [23] = '{24, 23, 22, 21, 20, 19, 18, 17, 16,
                     7, 6, 5, 4, 3, 2, 1, 0,
                     35, 34, 33, 32, 49, 48};

  biquad_coeff_loader #(
    .NUM_BIQUADS (NB),
    .COEFF_WIDTH (CW),
    .WR_HOLD     (H)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_wr_i      (host_wr_i),
    .host_stage_i   (host_stage_i),
    .host_adr_i     (host_adr_i),
    .host_dat_i     (host_dat_i),
    .host_ready_o   (host_ready_o),
    .host_err_o     (host_err_o),
    .commit_i       (commit_i),
    .commit_mask_i  (commit_mask_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .coeff_adr_o    (coeff_adr_o),
    .coeff_dat_o    (coeff_dat_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] coeff_val(input int stage, input int adr);
    return CW'((adr << 8) | ((stage == 0) ? 5 : 9));
  endfunction

  task automatic host_write(input int stage, input int adr, input logic [CW-1:0] dat);
    host_wr_i    = 1'b1;
    host_stage_i = 3'(stage);
    host_adr_i   = 8'(adr);
    host_dat_i   = dat;
    @(negedge clk);
    host_wr_i    = 1'b0;
  endtask

  // Commit with the given mask and check every cycle against the timing model
  task automatic run_stream(input logic [NB-1:0] mask, input int inject_at, input int abort_at);
    int stages [2];
    int s;
    int last;
    int t;
    int ent;
    int ph;
    int adr;
    logic [NB-1:0] exp_wr;
    s = 0;
    for (int i = 0; i < int'(NB); i++) begin
      if (mask[i]) begin
        stages[s] = i;
        s++;
      end
    end
    last = 1 + 23 * (int'(H) + 2) * s;
    commit_i      = 1'b1;
    commit_mask_i = mask;
    @(posedge clk);
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      if (n == 1) commit_i = 1'b0;
      if (n == inject_at + 1) begin
        commit_i  = 1'b0;
        host_wr_i = 1'b0;
      end
      t      = n - 1;
      ent    = t / (int'(H) + 2);
      ph     = t % (int'(H) + 2);
      exp_wr = '0;
      if (ent < 23 * s && ph >= 1 && ph <= int'(H)) exp_wr = NB'(1) << stages[ent / 23];
      check("coeff_wr", 32'(coeff_wr_o), 32'(exp_wr));
      if (exp_wr != '0) begin
        adr = order[ent % 23];
        check("coeff_adr", 32'(coeff_adr_o), 32'(adr));
        check("coeff_dat", 32'(coeff_dat_o), 32'(coeff_val(stages[ent / 23], adr)));
      end
      check("coeff_update", 32'(coeff_update_o), 32'(n == last));
      check("done", 32'(done_o), 32'(n == last + 1));
      if (n == 1) begin
        check("busy_start", 32'(busy_o), 32'd1);
        check("ready_busy", 32'(host_ready_o), 32'd0);
        check("err_cleared", 32'(host_err_o), 32'd0);
      end
      if (n == inject_at + 2) check("err_busy_write", 32'(host_err_o), 32'd1);
      if (n == inject_at) begin
        commit_i      = 1'b1;
        commit_mask_i = 2'b11;
        host_wr_i     = 1'b1;
        host_stage_i  = 3'd0;
        host_adr_i    = 8'd0;
        host_dat_i    = 18'h3FFFF;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_wr", 32'(coeff_wr_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 480; m++) begin
          @(negedge clk);
          check("abort_no_update", 32'(coeff_update_o), 32'd0);
          check("abort_no_wr", 32'(coeff_wr_o), 32'd0);
        end
        return;
      end
    end
    @(negedge clk);
    check("busy_end", 32'(busy_o), 32'd0);
    check("ready_end", 32'(host_ready_o), 32'd1);
  endtask

  // Zero-mask commit: only a done pulse one cycle later
  task automatic zero_commit();
    commit_i      = 1'b1;
    commit_mask_i = '0;
    @(posedge clk);
    @(negedge clk);
    commit_i = 1'b0;
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_wr", 32'(coeff_wr_o), 32'd0);
    check("zero_err_clr", 32'(host_err_o), 32'd0);
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      check("zero_done_off", 32'(done_o), 32'd0);
      check("zero_no_wr", 32'(coeff_wr_o), 32'd0);
      check("zero_no_update", 32'(coeff_update_o), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    host_wr_i     = 1'b0;
    host_stage_i  = '0;
    host_adr_i    = '0;
    host_dat_i    = '0;
    commit_i      = 1'b0;
    commit_mask_i = '0;
    #23;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wr", 32'(coeff_wr_o), 32'd0);
    check("rst_update", 32'(coeff_update_o), 32'd0);
    check("rst_err", 32'(host_err_o), 32'd0);
    check("rst_adr", 32'(coeff_adr_o), 32'd0);
    check("rst_dat", 32'(coeff_dat_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int st = 0; st < 2; st++) begin
      for (int i = 0; i < 23; i++) host_write(st, order[i], coeff_val(st, order[i]));
    end
    check("load_err", 32'(host_err_o), 32'd0);
    check("load_ready", 32'(host_ready_o), 32'd1);

    run_stream(2'b01, -10, -10);
    run_stream(2'b11, -10, -10);

    host_write(0, 10, 18'h1234);
    check("err_bad_adr", 32'(host_err_o), 32'd1);
    zero_commit();
    host_write(3, 0, 18'h1234);
    check("err_bad_stage", 32'(host_err_o), 32'd1);
    zero_commit();

    run_stream(2'b01, 50, -10);
    run_stream(2'b01, -10, 100);
    check("post_abort_busy", 32'(busy_o), 32'd0);
    run_stream(2'b01, -10, -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
